// File: rtl/change_dispenser.sv
// Change dispenser: pays out a requested amount (in nickel units) as single-cycle
// dime/nickel pulses, greedy dimes-first, while tracking on-board coin stock.
module change_dispenser #(
  parameter int unsigned AMOUNT_W   = 5,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned DIME_CAP   = 15,
  parameter int unsigned NICKEL_CAP = 15,
  parameter int unsigned GAP        = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_req_valid,
  output logic                io_req_ready,
  input  logic [AMOUNT_W-1:0] io_req_amount,
  input  logic                io_refill,
  output logic                io_nickel,
  output logic                io_dime,
  output logic                io_done,
  output logic                io_short,
  output logic [CNT_W-1:0]    io_dime_cnt,
  output logic [CNT_W-1:0]    io_nickel_cnt
);

  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StGap, StDone} state_e;

  state_e              r_state;
  logic [AMOUNT_W-1:0] r_rem;
  logic                r_short;
  logic [CNT_W-1:0]    r_dime_cnt;
  logic [CNT_W-1:0]    r_nickel_cnt;
  logic [GapW-1:0]     r_gap_cnt;

  logic                w_can_dime;
  logic                w_can_nickel;
  logic [AMOUNT_W-1:0] w_rem_after;

  // Coin decision depends only on registered state, so outputs have no input path.
  assign w_can_dime   = (r_rem >= AMOUNT_W'(2)) && (r_dime_cnt != '0);
  assign w_can_nickel = !w_can_dime && (r_rem != '0) && (r_nickel_cnt != '0);
  assign w_rem_after  = w_can_dime ? (r_rem - AMOUNT_W'(2)) : (r_rem - AMOUNT_W'(1));

  assign io_req_ready  = (r_state == StIdle);
  assign io_dime       = (r_state == StIssue) && w_can_dime;
  assign io_nickel     = (r_state == StIssue) && w_can_nickel;
  assign io_done       = (r_state == StDone);
  assign io_short      = (r_state == StDone) && r_short;
  assign io_dime_cnt   = r_dime_cnt;
  assign io_nickel_cnt = r_nickel_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_rem        <= '0;
      r_short      <= 1'b0;
      r_dime_cnt   <= CNT_W'(DIME_CAP);
      r_nickel_cnt <= CNT_W'(NICKEL_CAP);
      r_gap_cnt    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (io_refill) begin
            r_dime_cnt   <= CNT_W'(DIME_CAP);
            r_nickel_cnt <= CNT_W'(NICKEL_CAP);
          end
          if (io_req_valid) begin
            r_rem   <= io_req_amount;
            r_short <= 1'b0;
            r_state <= (io_req_amount == '0) ? StDone : StIssue;
          end
        end
        StIssue: begin
          if (w_can_dime || w_can_nickel) begin
            if (w_can_dime) r_dime_cnt <= r_dime_cnt - CNT_W'(1);
            else            r_nickel_cnt <= r_nickel_cnt - CNT_W'(1);
            r_rem <= w_rem_after;
            if (w_rem_after == '0) begin
              r_state <= StDone;
            end else if (GAP > 0) begin
              r_state   <= StGap;
              r_gap_cnt <= GapW'(GAP - 1);
            end
          end else begin
            r_short <= 1'b1;
            r_state <= StDone;
          end
        end
        StGap: begin
          if (r_gap_cnt == '0) r_state <= StIssue;
          else                 r_gap_cnt <= r_gap_cnt - GapW'(1);
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
